// File: rtl/ahb_mem_bist.sv
// AHB-Lite 64-bit memory BIST initiator: writes P(A) = {A ^ SEED, A} over a word window,
// reads it back, compares each word and reports pass/fail plus the first failing address.
module ahb_mem_bist #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned WORDS     = 4096,
  parameter logic [31:0] SEED      = 32'hA5A5_5A5A
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_pass,
  output logic        o_bus_err,
  output logic [31:0] o_err_addr,
  output logic [31:0] o_haddr,
  output logic [2:0]  o_hburst,
  output logic [2:0]  o_hsize,
  output logic [3:0]  o_hprot,
  output logic [1:0]  o_htrans,
  output logic [63:0] o_hwdata,
  output logic        o_hwrite,
  input  logic [63:0] i_hrdata,
  input  logic        i_hresp,
  input  logic        i_hready
);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_WR_DRAIN, S_RD, S_RD_DRAIN, S_DONE} state_t;

  localparam logic [1:0]  HT_IDLE   = 2'b00;
  localparam logic [1:0]  HT_NONSEQ = 2'b10;
  localparam logic [20:0] WORDS_N   = 21'(WORDS);

  state_t      state;
  logic [20:0] addr_left;   // address phases still to issue in the current pass
  logic        dp_valid;    // a data phase is outstanding
  logic [31:0] dp_addr;
  logic        abort;       // bus error seen: stop issuing, drain, finish
  logic        mis;         // a read mismatch was seen; later read data is ignored
  logic        berr;
  logic        err_hit;     // o_err_addr already holds the first failure

  logic accept, dp_done, rd_phase, mismatch;

  function automatic logic [63:0] pattern(input logic [31:0] a);
    return {a ^ SEED, a};
  endfunction

  assign o_hburst = 3'b000;
  assign o_hsize  = 3'b011;
  assign o_hprot  = 4'b0011;

  always_comb begin
    accept   = (o_htrans == HT_NONSEQ) && i_hready;
    dp_done  = dp_valid && i_hready;
    rd_phase = (state == S_RD) || (state == S_RD_DRAIN);
    mismatch = dp_done && rd_phase && !mis && (i_hrdata != pattern(dp_addr));
  end

  // NOTE: all state and bus outputs update with non-blocking assignments so every
  // decision below sees the pre-edge values; later assignments deliberately override earlier ones.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= S_IDLE;
      addr_left  <= '0;
      dp_valid   <= 1'b0;
      dp_addr    <= '0;
      abort      <= 1'b0;
      mis        <= 1'b0;
      berr       <= 1'b0;
      err_hit    <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_pass     <= 1'b0;
      o_bus_err  <= 1'b0;
      o_err_addr <= '0;
      o_htrans   <= HT_IDLE;
      o_haddr    <= '0;
      o_hwdata   <= '0;
      o_hwrite   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            state      <= S_WR;
            o_busy     <= 1'b1;
            o_done     <= 1'b0;
            o_pass     <= 1'b0;
            o_bus_err  <= 1'b0;
            o_err_addr <= '0;
            abort      <= 1'b0;
            mis        <= 1'b0;
            berr       <= 1'b0;
            err_hit    <= 1'b0;
            dp_valid   <= 1'b0;
            o_htrans   <= HT_NONSEQ;
            o_haddr    <= BASE_ADDR;
            o_hwrite   <= 1'b1;
            addr_left  <= WORDS_N;
          end
        end
        default: begin
          if (dp_done) dp_valid <= 1'b0;

          // Accepted address moves into its data phase; the last one closes the pass.
          if (accept) begin
            dp_valid  <= 1'b1;
            dp_addr   <= o_haddr;
            o_haddr   <= o_haddr + 32'd8;
            addr_left <= addr_left - 21'd1;
            if (o_hwrite) o_hwdata <= pattern(o_haddr);
            if (addr_left == 21'd1) begin
              o_htrans <= HT_IDLE;
              state    <= o_hwrite ? S_WR_DRAIN : S_RD_DRAIN;
            end
          end

          // One idle turnaround cycle after the write pass before the first read.
          if (state == S_RD && o_htrans == HT_IDLE && !abort) o_htrans <= HT_NONSEQ;

          if (state == S_WR_DRAIN && dp_done && !i_hresp && !abort) begin
            state     <= S_RD;
            o_hwrite  <= 1'b0;
            o_haddr   <= BASE_ADDR;
            addr_left <= WORDS_N;
          end

          // ERROR response: cancel the pending address phase and finish after the drain.
          if (dp_valid && i_hresp) begin
            berr     <= 1'b1;
            abort    <= 1'b1;
            o_htrans <= HT_IDLE;
            if (!err_hit) begin
              err_hit    <= 1'b1;
              o_err_addr <= dp_addr;
            end
          end

          if (mismatch) begin
            mis      <= 1'b1;
            o_htrans <= HT_IDLE;
            state    <= S_RD_DRAIN;
            if (!err_hit) begin
              err_hit    <= 1'b1;
              o_err_addr <= dp_addr;
            end
          end

          if ((abort || state == S_RD_DRAIN) && !dp_valid) begin
            state     <= S_DONE;
            o_busy    <= 1'b0;
            o_done    <= 1'b1;
            o_pass    <= !(mis || berr);
            o_bus_err <= berr;
            o_htrans  <= HT_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_mem_bist.sv
// Directed bench for ahb_mem_bist: three instances (WORDS = 4, 8, 16) share one AHB memory
// model that can stall, corrupt a read word or return a two-cycle ERROR.
module tb_ahb_mem_bist;

  localparam logic [31:0] SEED      = 32'hA5A5_5A5A;
  localparam logic [1:0]  HT_IDLE   = 2'b00;
  localparam logic [1:0]  HT_NONSEQ = 2'b10;

  logic        clk;
  logic        rst;
  logic        start_v [3];
  logic [63:0] hrdata;
  logic        hresp;
  logic        hready;

  logic        busy_v [3], done_v [3], pass_v [3], berr_v [3], hwrite_v [3];
  logic [31:0] err_addr_v [3], haddr_v [3];
  logic [2:0]  hburst_v [3], hsize_v [3];
  logic [3:0]  hprot_v [3];
  logic [1:0]  htrans_v [3];
  logic [63:0] hwdata_v [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W = (g == 0) ? 4 : ((g == 1) ? 8 : 16);
    ahb_mem_bist #(.BASE_ADDR(32'h0), .WORDS(W), .SEED(SEED)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_start(start_v[g]),
      .o_busy(busy_v[g]), .o_done(done_v[g]), .o_pass(pass_v[g]), .o_bus_err(berr_v[g]),
      .o_err_addr(err_addr_v[g]), .o_haddr(haddr_v[g]), .o_hburst(hburst_v[g]),
      .o_hsize(hsize_v[g]), .o_hprot(hprot_v[g]), .o_htrans(htrans_v[g]),
      .o_hwdata(hwdata_v[g]), .o_hwrite(hwrite_v[g]),
      .i_hrdata(hrdata), .i_hresp(hresp), .i_hready(hready)
    );
  end

  // View of the instance currently under test
  logic [1:0]  sel;
  logic        busy, done, pass, bus_err, hwrite;
  logic [31:0] err_addr, haddr;
  logic [2:0]  hburst, hsize;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic [63:0] hwdata;

  always_comb begin
    busy = busy_v[sel];   done = done_v[sel];     pass = pass_v[sel];
    bus_err = berr_v[sel]; hwrite = hwrite_v[sel]; err_addr = err_addr_v[sel];
    haddr = haddr_v[sel]; hburst = hburst_v[sel]; hsize = hsize_v[sel];
    hprot = hprot_v[sel]; htrans = htrans_v[sel]; hwdata = hwdata_v[sel];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory responder and bus monitor
  logic [63:0] mem [64];
  int          wr_cnt [64];
  logic        bm_valid, bm_write;
  logic [31:0] bm_addr;
  logic        held, held_write, prev_resp;
  logic [31:0] held_addr;
  int          hold_viol, bad_trans, rd_issued;
  logic [31:0] rd_max;

  int          stall_pct;
  logic        corrupt_en, err_en;
  logic [31:0] corrupt_at, err_at;
  int          err_stage;

  always @(posedge clk) begin
    if (rst) begin
      bm_valid <= 1'b0; bm_write <= 1'b0; bm_addr <= '0;
      held <= 1'b0; held_write <= 1'b0; held_addr <= '0; prev_resp <= 1'b0;
      hold_viol <= 0; bad_trans <= 0; rd_issued <= 0; rd_max <= '0;
      for (int i = 0; i < 64; i++) begin
        mem[i]    <= '0;
        wr_cnt[i] <= 0;
      end
    end else begin
      if (htrans != HT_IDLE && htrans != HT_NONSEQ) bad_trans <= bad_trans + 1;
      if (held && !prev_resp && (htrans != HT_NONSEQ || haddr != held_addr || hwrite != held_write))
        hold_viol <= hold_viol + 1;
      held       <= (htrans == HT_NONSEQ) && !hready;
      held_addr  <= haddr;
      held_write <= hwrite;
      prev_resp  <= hresp;
      if (hready) begin
        if (bm_valid && bm_write && !hresp) begin
          mem[bm_addr[8:3]]    <= hwdata;
          wr_cnt[bm_addr[8:3]] <= wr_cnt[bm_addr[8:3]] + 1;
        end
        bm_valid <= (htrans == HT_NONSEQ);
        bm_addr  <= haddr;
        bm_write <= hwrite;
        if (htrans == HT_NONSEQ && !hwrite) begin
          rd_issued <= rd_issued + 1;
          if (haddr > rd_max) rd_max <= haddr;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      err_stage = 0;
      hready    = 1'b1;
      hresp     = 1'b0;
      hrdata    = '0;
    end else begin
      hresp  = 1'b0;
      hready = (int'($urandom_range(0, 99)) >= stall_pct);
      if (err_en && err_stage == 0 && bm_valid && bm_write && bm_addr == err_at) begin
        hresp = 1'b1; hready = 1'b0; err_stage = 1;
      end else if (err_stage == 1) begin
        hresp = 1'b1; hready = 1'b1; err_stage = 2;
      end
      hrdata = mem[bm_addr[8:3]];
      if (corrupt_en && bm_addr == corrupt_at) hrdata = hrdata ^ 64'h1;
    end
  end

  int vectors;
  int miscompares;

  function automatic logic [63:0] pat(input logic [31:0] a);
    return {a ^ SEED, a};
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] s);
    rst = 1'b1;
    sel = s;
    stall_pct = 0; corrupt_en = 1'b0; err_en = 1'b0;
    corrupt_at = '0; err_at = '0;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic pulse_start(input int idx);
    start_v[idx] = 1'b1;
    step();
    start_v[idx] = 1'b0;
  endtask

  // Returns the number of edges after the start edge at which o_done was first seen
  task automatic wait_done(input int n0, input int budget, output int n);
    n = n0;
    while (done !== 1'b1 && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    do_reset(2'd0);
    vectors++;
    if ({busy, done, pass, bus_err, hwrite, htrans} !== 7'b0) begin
      miscompares++; $display("FAIL reset_ctrl: got %b expected 0", {busy, done, pass, bus_err, hwrite, htrans});
    end
    vectors++;
    if (haddr !== 32'h0 || err_addr !== 32'h0) begin
      miscompares++; $display("FAIL reset_addr: haddr %h err_addr %h expected 0", haddr, err_addr);
    end
    vectors++;
    if (hwdata !== 64'h0) begin
      miscompares++; $display("FAIL reset_hwdata: got %h expected 0", hwdata);
    end
    vectors++;
    if ({hburst, hsize, hprot} !== {3'b000, 3'b011, 4'b0011}) begin
      miscompares++; $display("FAIL bus_consts: got %b expected 0000110011", {hburst, hsize, hprot});
    end
  endtask

  task automatic test_basic();
    int n;
    do_reset(2'd0);
    pulse_start(0);
    vectors++;
    if ({busy, htrans, hwrite} !== {1'b1, HT_NONSEQ, 1'b1} || haddr !== 32'h0) begin
      miscompares++; $display("FAIL first_addr: busy/htrans/hwrite %b haddr %h expected 1101 0", {busy, htrans, hwrite}, haddr);
    end
    step();
    vectors++;
    if (haddr !== 32'h8) begin
      miscompares++; $display("FAIL addr_advance: got %h expected 8", haddr);
    end
    step();
    vectors++;
    if (hwdata !== 64'hA5A5_5A52_0000_0008) begin
      miscompares++; $display("FAIL hwdata_0x8: got %h expected a5a55a5200000008", hwdata);
    end
    wait_done(2, 100, n);
    vectors++;
    if (n !== 12 || done !== 1'b1) begin
      miscompares++; $display("FAIL latency_w4: done %b at edge %0d expected 1 at 12", done, n);
    end
    vectors++;
    if ({pass, bus_err, busy} !== 3'b100 || err_addr !== 32'h0) begin
      miscompares++; $display("FAIL status_w4: pass/berr/busy %b err_addr %h expected 100 0", {pass, bus_err, busy}, err_addr);
    end
    vectors++;
    if (mem[3] !== 64'hA5A5_5A42_0000_0018) begin
      miscompares++; $display("FAIL mem_0x18: got %h expected a5a55a4200000018", mem[3]);
    end
  endtask

  task automatic test_stall();
    int n, bad_wr, bad_data;
    do_reset(2'd2);
    stall_pct = 50;
    pulse_start(2);
    wait_done(0, 2000, n);
    vectors++;
    if (done !== 1'b1 || pass !== 1'b1) begin
      miscompares++; $display("FAIL stall_pass: done %b pass %b expected 1 1", done, pass);
    end
    vectors++;
    if (hold_viol !== 0 || bad_trans !== 0) begin
      miscompares++; $display("FAIL stall_hold: hold violations %0d bad htrans %0d expected 0 0", hold_viol, bad_trans);
    end
    bad_wr = 0;
    bad_data = 0;
    for (int i = 0; i < 20; i++) begin
      if (wr_cnt[i] != ((i < 16) ? 1 : 0)) bad_wr++;
      if (i < 16 && mem[i] !== pat(32'(i * 8))) bad_data++;
    end
    vectors++;
    if (bad_wr !== 0) begin
      miscompares++; $display("FAIL stall_write_once: %0d words with wrong write count, expected 0", bad_wr);
    end
    vectors++;
    if (bad_data !== 0) begin
      miscompares++; $display("FAIL stall_mem: %0d words with wrong data, expected 0", bad_data);
    end
  endtask

  task automatic test_mismatch();
    int n;
    do_reset(2'd1);
    corrupt_en = 1'b1;
    corrupt_at = 32'h18;
    pulse_start(1);
    wait_done(0, 200, n);
    vectors++;
    if ({done, pass, bus_err} !== 3'b100) begin
      miscompares++; $display("FAIL mis_status: done/pass/berr %b expected 100", {done, pass, bus_err});
    end
    vectors++;
    if (err_addr !== 32'h18) begin
      miscompares++; $display("FAIL mis_err_addr: got %h expected 18", err_addr);
    end
    vectors++;
    if (rd_max !== 32'h20 || rd_issued !== 5) begin
      miscompares++; $display("FAIL mis_stop: last read %h count %0d expected 20 5", rd_max, rd_issued);
    end
  endtask

  task automatic test_bus_err();
    int n;
    do_reset(2'd1);
    err_en = 1'b1;
    err_at = 32'h10;
    pulse_start(1);
    n = 0;
    while (!(hresp === 1'b1 && hready === 1'b0) && n < 50) begin
      step();
      n++;
    end
    step();
    vectors++;
    if (htrans !== HT_IDLE) begin
      miscompares++; $display("FAIL err_cancel: htrans %b expected 00", htrans);
    end
    wait_done(0, 50, n);
    vectors++;
    if ({done, pass, bus_err} !== 3'b101) begin
      miscompares++; $display("FAIL err_status: done/pass/berr %b expected 101", {done, pass, bus_err});
    end
    vectors++;
    if (err_addr !== 32'h10) begin
      miscompares++; $display("FAIL err_addr: got %h expected 10", err_addr);
    end
    vectors++;
    if (wr_cnt[2] !== 0 || wr_cnt[3] !== 0) begin
      miscompares++; $display("FAIL err_no_commit: writes at 0x10 %0d 0x18 %0d expected 0 0", wr_cnt[2], wr_cnt[3]);
    end
  endtask

  task automatic test_reset_mid_run();
    int n;
    do_reset(2'd1);
    pulse_start(1);
    n = 0;
    while (!(htrans === HT_NONSEQ && hwrite === 1'b0) && n < 100) begin
      step();
      n++;
    end
    step(); step();
    vectors++;
    if (busy !== 1'b1 || hwrite !== 1'b0) begin
      miscompares++; $display("FAIL mid_in_rd: busy %b hwrite %b expected 1 0", busy, hwrite);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({busy, done, pass, bus_err, hwrite, htrans} !== 7'b0 || haddr !== 32'h0 || hwdata !== 64'h0) begin
      miscompares++; $display("FAIL mid_async_reset: ctrl %b haddr %h hwdata %h expected 0", {busy, done, pass, bus_err, hwrite, htrans}, haddr, hwdata);
    end
    step();
    rst = 1'b0;
    step();
    pulse_start(1);
    wait_done(0, 200, n);
    vectors++;
    if ({done, pass, bus_err} !== 3'b110 || n !== 20) begin
      miscompares++; $display("FAIL mid_rerun: done/pass/berr %b at edge %0d expected 110 at 20", {done, pass, bus_err}, n);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    do_reset(2'd0);
    pulse_start(0);
    repeat (3) step();
    pulse_start(0);
    wait_done(4, 100, n);
    vectors++;
    if (n !== 12 || pass !== 1'b1) begin
      miscompares++; $display("FAIL busy_start_ignored: done at edge %0d pass %b expected 12 1", n, pass);
    end
    step();
    pulse_start(0);
    vectors++;
    if ({done, busy, htrans} !== {1'b0, 1'b1, HT_NONSEQ} || haddr !== 32'h0) begin
      miscompares++; $display("FAIL restart: done/busy/htrans %b haddr %h expected 0110 0", {done, busy, htrans}, haddr);
    end
    wait_done(0, 100, n);
    vectors++;
    if (n !== 12 || {done, pass, bus_err} !== 3'b110) begin
      miscompares++; $display("FAIL restart_done: done/pass/berr %b at edge %0d expected 110 at 12", {done, pass, bus_err}, n);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    sel = 2'd0;
    for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
    stall_pct = 0; corrupt_en = 1'b0; err_en = 1'b0;
    corrupt_at = '0; err_at = '0;
    test_reset();
    test_basic();
    test_stall();
    test_mismatch();
    test_bus_err();
    test_reset_mid_run();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
